// File: rtl/hamming_dec_engine.sv
// hamming_dec_engine
//
// Hamming(15,11) single-error-correcting decoder working against a byte-wide
// data memory. A request reads N_WORDS encoded words (two bytes each) starting
// at SRC_BASE. Each word is corrected for at most one flipped bit. The 11-bit
// message is written back as two bytes starting at DST_BASE. A one-cycle ack
// follows the last write.
//
// Encoded word c[15:1]:  low byte = c[8:1], high byte = {x, c[15:9]}
// Decoded message d[11:1]: low byte = d[8:1], high byte = {5'b0, d[11:9]}
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-low
//   req          in   start request, sampled only in IDLE
//   ack          out  one-cycle done pulse
//   mem_addr     out  [AW-1:0] byte address
//   mem_rd_data  in   [DW-1:0] read data, valid the cycle after mem_addr
//   mem_wr_en    out  write strobe
//   mem_wr_data  out  [DW-1:0] write data
//   err_count    out  [7:0] words with nonzero syndrome in the last run
//                     (only when HAMDEC_ERRCNT_EN is defined)
//
// Build option
//   HAMDEC_ERRCNT_EN : adds err_count and a final write of that count to
//                      DST_BASE+2*N_WORDS before ack.
//
// Handshake: req is a level sampled on a rising edge while the engine is
// idle; any req seen in other states is dropped. ack is high for exactly one
// cycle per completed run. All memory-side outputs are registered.

module hamming_dec_engine #(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int N_WORDS  = 15,
   parameter int SRC_BASE = 64,
   parameter int DST_BASE = 94
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   output logic          ack,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rd_data,
   output logic          mem_wr_en,
   output logic [DW-1:0] mem_wr_data
`ifdef HAMDEC_ERRCNT_EN
   ,
   output logic [7:0]    err_count
`endif
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_LO,
      S_RD_HI,
      S_CAP_HI,
      S_FIX,
      S_WR_LO,
      S_WR_HI,
      S_WR_CNT,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] SRC_A  = AW'(SRC_BASE);
   localparam logic [AW-1:0] DST_A  = AW'(DST_BASE);
   localparam logic [AW-1:0] ONE_A  = AW'(1);
   localparam logic [6:0]    LAST_I = 7'(N_WORDS - 1);
`ifdef HAMDEC_ERRCNT_EN
   localparam logic [AW-1:0] CNT_A  = AW'(DST_BASE + 2 * N_WORDS);
`endif

   state_t          state, state_nxt;
   logic [6:0]      i_q, i_nxt;
   logic [7:0]      lo_q;
   logic [6:0]      hi_q;
   logic [2:0]      d_hi_q;

   logic [14:0]     cw;
   logic [14:0]     cw_fix;
   logic [3:0]      syn;
   logic [10:0]     d_fix;

   logic [AW-1:0]   two_i;
   logic [AW-1:0]   addr_nxt;
   logic            wr_en_nxt;
   logic [DW-1:0]   wr_data_nxt;
   logic            ack_nxt;

`ifdef HAMDEC_ERRCNT_EN
   logic [7:0]      err_q;
   assign err_count = err_q;
`endif

   // Bit 7 of the encoded high byte carries no information.
   logic            unused_hi_bit7;
   assign unused_hi_bit7 = mem_rd_data[7];

   // Syndrome and correction. cw[k-1] holds code position k.
   always_comb begin
      cw     = {hi_q, lo_q};
      syn    = 4'd0;
      for (int k = 1; k <= 15; k++) begin
         if (cw[k-1]) syn = syn ^ 4'(k);
      end
      cw_fix = cw;
      if (syn != 4'd0) cw_fix = cw ^ (15'd1 << (syn - 4'd1));
      // d[11:5]=c[15:9], d[4:2]=c[7:5], d[1]=c[3]
      d_fix  = {cw_fix[14:8], cw_fix[6:4], cw_fix[2]};
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      i_nxt     = i_q;
      case (state)
         S_IDLE: begin
            if (req) begin
               state_nxt = S_RD_LO;
               i_nxt     = 7'd0;
            end
         end
         S_RD_LO:  state_nxt = S_RD_HI;
         S_RD_HI:  state_nxt = S_CAP_HI;
         S_CAP_HI: state_nxt = S_FIX;
         S_FIX:    state_nxt = S_WR_LO;
         S_WR_LO:  state_nxt = S_WR_HI;
         S_WR_HI: begin
            if (i_q < LAST_I) begin
               state_nxt = S_RD_LO;
               i_nxt     = i_q + 7'd1;
            end else begin
`ifdef HAMDEC_ERRCNT_EN
               state_nxt = S_WR_CNT;
`else
               state_nxt = S_DONE;
`endif
            end
         end
         S_WR_CNT: state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Output values are derived from the state being entered so that the
   // registered memory outputs line up with that state's cycle.
   always_comb begin
      two_i       = AW'({i_nxt, 1'b0});
      addr_nxt    = mem_addr;
      wr_en_nxt   = 1'b0;
      wr_data_nxt = mem_wr_data;
      ack_nxt     = (state == S_DONE);
      case (state_nxt)
         S_RD_LO: addr_nxt = SRC_A + two_i;
         S_RD_HI: addr_nxt = SRC_A + two_i + ONE_A;
         S_WR_LO: begin
            // Entered only from FIX, so the freshly corrected word is used.
            addr_nxt    = DST_A + two_i;
            wr_en_nxt   = 1'b1;
            wr_data_nxt = DW'(d_fix[7:0]);
         end
         S_WR_HI: begin
            addr_nxt    = DST_A + two_i + ONE_A;
            wr_en_nxt   = 1'b1;
            wr_data_nxt = DW'({5'b0, d_hi_q});
         end
`ifdef HAMDEC_ERRCNT_EN
         S_WR_CNT: begin
            addr_nxt    = CNT_A;
            wr_en_nxt   = 1'b1;
            wr_data_nxt = DW'(err_q);
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         i_q         <= '0;
         lo_q        <= '0;
         hi_q        <= '0;
         d_hi_q      <= '0;
         ack         <= 1'b0;
         mem_addr    <= '0;
         mem_wr_en   <= 1'b0;
         mem_wr_data <= '0;
`ifdef HAMDEC_ERRCNT_EN
         err_q       <= '0;
`endif
      end else begin
         state       <= state_nxt;
         i_q         <= i_nxt;
         ack         <= ack_nxt;
         mem_addr    <= addr_nxt;
         mem_wr_en   <= wr_en_nxt;
         mem_wr_data <= wr_data_nxt;
         if (state == S_RD_HI)  lo_q   <= mem_rd_data[7:0];
         if (state == S_CAP_HI) hi_q   <= mem_rd_data[6:0];
         if (state == S_FIX)    d_hi_q <= d_fix[10:8];
`ifdef HAMDEC_ERRCNT_EN
         if (state == S_IDLE && req) begin
            err_q <= '0;
         end else if (state == S_FIX && syn != 4'd0 && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
         end
`endif
      end
   end

endmodule
